pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
//   Program-counter register and next-PC selector for the multicycle core. Consumes PC+2 from
//   the incrementer stage and drives the current PC back to it and to instruction fetch.
//   Selects among sequential, branch, jump and return targets.
//   Contains a small return-address stack (RAS) for CALL/RET.
//   Updates only on cycles where the control FSM asserts pc_write.
// PARAMETERS
//   PC_W       16       PC / address width (bits)
//   RESET_VEC  16'h0000 PC value loaded on reset
//   RAS_DEPTH  8        return-address stack entries (power of 2, >=2)
// PORTS
//   clk           in   1     system clock, all state on rising edge
//   rst           in   1     synchronous reset, active-high
//   pc_write      in   1     commit next PC this cycle (from control FSM)
//   pc_src        in   2     00 INC, 01 BRANCH, 10 JUMP, 11 RET
//   branch_taken  in   1     condition result; used only when pc_src=BRANCH
//   branch_off    in   PC_W  signed byte offset, relative to current pc_out
//   jump_target   in   PC_W  absolute jump/call target
//   is_call       in   1     with pc_src=JUMP: push return address
//   pc_plus2      in   PC_W  pc_out+2 from incrementer stage
//   err_clr       in   1     clears sticky ras_err
//   pc_out        out  PC_W  current PC (registered)
//   ras_empty     out  1     RAS holds 0 entries
//   ras_full      out  1     RAS holds RAS_DEPTH entries
//   ras_err       out  1     sticky: overflow or underflow occurred
//   align_fault   out  1     1-cycle pulse: selected target had bit0=1
// BEHAVIOUR
//   Reset (rst=1 at edge): pc_out=RESET_VEC, RAS count=0, ras_empty=1, ras_full=0,
//     ras_err=0, align_fault=0. rst has priority over all other inputs.
//   pc_write=0: pc_out, RAS and flags hold; align_fault=0. push/pop are suppressed.
//   pc_write=1: next pc_out, visible the cycle after the edge (latency 1):
//     INC    -> pc_plus2
//     BRANCH -> taken ? pc_out+branch_off : pc_plus2
//     JUMP   -> jump_target; if is_call, also push pc_plus2
//     RET    -> RAS top, then pop; if empty, pc_plus2 instead, no pop, ras_err<=1
//   Arithmetic: PC_W-bit modulo 2^PC_W. FFFE+0004=0002; 0002+FFFA=FFFC. No carry out.
//   Alignment: bit0 of the selected target is forced to 0 before the load.
//     align_fault=1 for that one cycle if the raw bit0 was 1. Only the INC path never faults.
//   is_call is ignored unless pc_src=JUMP.
//   RAS: circular buffer, top pointer and count of 0..RAS_DEPTH.
//     push when full: overwrite oldest entry, count stays RAS_DEPTH, ras_err<=1.
//     pop when empty: see RET above.
//   A single instruction never pushes and pops together; encoding excludes it.
//   ras_empty and ras_full are registered and derived from the count after the update.
//   ras_err: set on overflow or underflow. Cleared by err_clr when no new error occurs
//     in that cycle; a set in the same cycle wins over the clear.
//   pc_plus2 is trusted as pc_out+2; there is no internal check.
// STRUCTURE
//   Shared package pc_pkg: pc_src encodings (PC_INC/PC_BR/PC_JMP/PC_RET) and the
//     RESET_VEC default.
//   Sub-module ras_stack (clk, rst, push, pop, din, dout, empty, full, ovf, unf):
//     the circular stack. The top level holds the PC register, target mux, alignment
//     logic and sticky flag.
// TESTING
//   1 rst high 2 cycles, then pc_write=1 INC x3 -> pc_out 0000,0002,0004,0006;
//     ras_empty=1, ras_err=0.
//   2 pc_out=0010, BRANCH taken off=FFF0 -> 0000; not-taken -> 0012;
//     pc_out=FFFE taken off=0004 -> 0002 (wrap).
//   3 pc_out=0100, JUMP is_call target=0200 -> pc 0200, RAS top 0102.
//     Nested call at 0200 to 0300, then RET, RET -> 0202, then 0102; ras_empty=1.
//   4 9 calls with RAS_DEPTH=8 -> ras_full=1, ras_err=1 on 9th.
//     8 RETs return newest 8 addresses. 9th RET -> pc_plus2, ras_err stays 1.
//     err_clr -> 0.
//   5 pc_write=0 for 5 cycles with pc_src=RET, is_call=1 -> pc_out and RAS unchanged.
//     JUMP target=0205 -> pc 0204, align_fault pulses 1 cycle.
//   6 rst asserted mid-sequence with 3 RAS entries -> next cycle pc_out=RESET_VEC,
//     ras_empty=1, ras_err=0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the next-PC unit.
//   pc_src_e     : next-PC source select encodings
//   RESET_VEC_DEF: default PC value loaded on reset
package pc_pkg;
  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_RET = 2'b11
  } pc_src_e;

  localparam logic [15:0] RESET_VEC_DEF = 16'h0000;
endpackage

// File: rtl/pc_next_unit_ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, rst   : clock, synchronous active-high reset
//   push, pop  : stack operations (never both in one cycle)
//   din        : address pushed
//   dout       : current top entry (combinational read)
//   empty/full : registered occupancy flags, reflect count after update
//   ovf/unf    : combinational strobes, push-when-full / pop-when-empty
module ras_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] top, top_inc, top_dec;
  logic [CW-1:0] cnt, cnt_nxt;

  assign top_inc = top + PW'(1);
  assign top_dec = top - PW'(1);
  assign ovf     = push && (cnt == CNT_MAX);
  assign unf     = pop && (cnt == '0);
  assign dout    = mem[top];

  // A push when full still advances top, overwriting the oldest slot;
  // only the count saturates.
  always_comb begin
    cnt_nxt = cnt;
    if (push && !ovf)     cnt_nxt = cnt + CW'(1);
    else if (pop && !unf) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top   <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == CNT_MAX);
      if (push)             top <= top_inc;
      else if (pop && !unf) top <= top_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[top_inc] <= din;
  end
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register and next-PC selector with return-address stack.
//   clk, rst     : clock, synchronous active-high reset
//   pc_write     : commit the selected next PC this cycle
//   pc_src       : 00 INC, 01 BRANCH, 10 JUMP, 11 RET
//   branch_taken : branch condition (BRANCH only)
//   branch_off   : signed offset added to pc_out on a taken branch
//   jump_target  : absolute jump/call target
//   is_call      : with JUMP, push pc_plus2 as return address
//   pc_plus2     : pc_out+2 from the incrementer
//   err_clr      : clears sticky ras_err
//   pc_out       : current PC
//   ras_empty/full, ras_err (sticky), align_fault (1-cycle pulse)
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
  parameter int              RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic [1:0]      pc_src,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_off,
  input  logic [PC_W-1:0] jump_target,
  input  logic            is_call,
  input  logic [PC_W-1:0] pc_plus2,
  input  logic            err_clr,
  output logic [PC_W-1:0] pc_out,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err,
  output logic            align_fault
);
  pc_src_e         src;
  logic [PC_W-1:0] raw, ras_dout;
  logic            push, pop, ovf, unf, raw_fault;

  assign src  = pc_src_e'(pc_src);
  assign push = pc_write && (src == PC_JMP) && is_call;
  assign pop  = pc_write && (src == PC_RET);

  ras_stack #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (pc_plus2),
    .dout (ras_dout),
    .empty(ras_empty),
    .full (ras_full),
    .ovf  (ovf),
    .unf  (unf)
  );

  // RET on an empty stack falls through to the sequential address.
  always_comb begin
    raw = pc_plus2;
    case (src)
      PC_BR:   if (branch_taken) raw = pc_out + branch_off;
      PC_JMP:  raw = jump_target;
      PC_RET:  if (!ras_empty) raw = ras_dout;
      default: raw = pc_plus2;
    endcase
  end

  // pc_plus2 is assumed even, so the INC path is excluded from faulting.
  assign raw_fault = (src != PC_INC) && raw[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out      <= RESET_VEC;
      ras_err     <= 1'b0;
      align_fault <= 1'b0;
    end else begin
      align_fault <= pc_write && raw_fault;
      if (pc_write) pc_out <= {raw[PC_W-1:1], 1'b0};
      if (ovf || unf)   ras_err <= 1'b1;
      else if (err_clr) ras_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_write = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_off = '0;
  logic [15:0] jump_target = '0;
  logic        is_call = 1'b0;
  logic [15:0] pc_plus2 = 16'd2;
  logic        err_clr = 1'b0;
  logic [15:0] pc_out;
  logic        ras_empty, ras_full, ras_err, align_fault;

  int errors = 0;
  int checks = 0;

  // reference model: queue back = newest return address
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] q[$];
  logic        m_err = 1'b0;
  logic        m_fault = 1'b0;

  logic [19:0] obs;
  assign obs = {pc_out, ras_empty, ras_full, ras_err, align_fault};

  pc_next_unit dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_src(pc_src),
    .branch_taken(branch_taken), .branch_off(branch_off),
    .jump_target(jump_target), .is_call(is_call), .pc_plus2(pc_plus2),
    .err_clr(err_clr), .pc_out(pc_out), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_err(ras_err), .align_fault(align_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] exp_vec();
    return {m_pc, q.size() == 0, q.size() == DEPTH, m_err, m_fault};
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    pc_write = 1'b0;
    repeat (cycles) @(posedge clk);
    m_pc = 16'h0000;
    q.delete();
    m_err = 1'b0;
    m_fault = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic wr, input logic [1:0] src, input logic tk,
                      input logic [15:0] off, input logic [15:0] tgt,
                      input logic call, input logic clr);
    logic [15:0] nxt;
    logic        newerr;
    @(negedge clk);
    pc_write = wr; pc_src = src; branch_taken = tk; branch_off = off;
    jump_target = tgt; is_call = call; err_clr = clr;
    pc_plus2 = m_pc + 16'd2;
    @(posedge clk);
    newerr = 1'b0;
    nxt = m_pc + 16'd2;
    if (wr) begin
      if (src == 2'b01 && tk) nxt = m_pc + off;
      if (src == 2'b10) begin
        nxt = tgt;
        if (call) begin
          q.push_back(m_pc + 16'd2);
          if (q.size() > DEPTH) begin
            void'(q.pop_front());
            newerr = 1'b1;
          end
        end
      end
      if (src == 2'b11) begin
        if (q.size() > 0) nxt = q.pop_back();
        else newerr = 1'b1;
      end
      m_fault = (src != 2'b00) && nxt[0];
      m_pc = {nxt[15:1], 1'b0};
    end else begin
      m_fault = 1'b0;
    end
    if (newerr) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if (obs !== 20'h0_0008) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs, 20'h0_0008);
    end
    for (int i = 1; i <= 3; i++) begin
      step(1, 2'b00, 0, 16'h0, 16'h0, 0, 0);
      checks++;
      if (obs !== {16'(2 * i), 4'b1000}) begin
        errors++; $display("FAIL inc_%0d: got %h want %h", i, obs, {16'(2 * i), 4'b1000});
      end
    end
  endtask

  task automatic test_branch();
    step(1, 2'b10, 0, 16'h0, 16'h0010, 0, 0);
    step(1, 2'b01, 1, 16'hFFF0, 16'h0, 0, 0);
    checks++;
    if (pc_out !== 16'h0000) begin
      errors++; $display("FAIL br_taken_back: got %h want 0000", pc_out);
    end
    step(1, 2'b10, 0, 16'h0, 16'h0010, 0, 0);
    step(1, 2'b01, 0, 16'hFFF0, 16'h0, 0, 0);
    checks++;
    if (pc_out !== 16'h0012) begin
      errors++; $display("FAIL br_not_taken: got %h want 0012", pc_out);
    end
    step(1, 2'b10, 0, 16'h0, 16'hFFFE, 0, 0);
    step(1, 2'b01, 1, 16'h0004, 16'h0, 0, 0);
    checks++;
    if (obs !== {16'h0002, 4'b1000}) begin
      errors++; $display("FAIL br_wrap: got %h want %h", obs, {16'h0002, 4'b1000});
    end
  endtask

  task automatic test_call_ret();
    step(1, 2'b10, 0, 16'h0, 16'h0100, 0, 0);
    step(1, 2'b10, 0, 16'h0, 16'h0200, 1, 0);
    checks++;
    if (obs !== {16'h0200, 4'b0000}) begin
      errors++; $display("FAIL call1: got %h want %h", obs, {16'h0200, 4'b0000});
    end
    step(1, 2'b10, 0, 16'h0, 16'h0300, 1, 0);
    step(1, 2'b11, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (pc_out !== 16'h0202) begin
      errors++; $display("FAIL ret1: got %h want 0202", pc_out);
    end
    step(1, 2'b11, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (obs !== {16'h0102, 4'b1000}) begin
      errors++; $display("FAIL ret2: got %h want %h", obs, {16'h0102, 4'b1000});
    end
  endtask

  task automatic test_overflow();
    logic [15:0] t;
    do_reset(1);
    for (int i = 0; i < 9; i++) begin
      t = 16'h1000 + 16'(i * 32);
      step(1, 2'b10, 0, 16'h0, t, 1, 0);
      if (i == 7) begin
        checks++;
        if ({ras_full, ras_err} !== 2'b10) begin
          errors++; $display("FAIL full_no_err: got %b want 10", {ras_full, ras_err});
        end
      end
    end
    checks++;
    if (obs !== {16'h1100, 4'b0110}) begin
      errors++; $display("FAIL ovf9: got %h want %h", obs, {16'h1100, 4'b0110});
    end
    for (int k = 0; k < 8; k++) begin
      step(1, 2'b11, 0, 16'h0, 16'h0, 0, 0);
      t = 16'h1000 + 16'((7 - k) * 32) + 16'd2;
      checks++;
      if (pc_out !== t || obs !== exp_vec()) begin
        errors++; $display("FAIL ret_%0d: got %h want pc %h vec %h", k, obs, t, exp_vec());
      end
    end
    step(1, 2'b11, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (obs !== {16'h1004, 4'b1010}) begin
      errors++; $display("FAIL unf_ret: got %h want %h", obs, {16'h1004, 4'b1010});
    end
    step(0, 2'b00, 0, 16'h0, 16'h0, 0, 1);
    checks++;
    if (ras_err !== 1'b0) begin
      errors++; $display("FAIL err_clr: got %b want 0", ras_err);
    end
  endtask

  task automatic test_hold_align();
    step(1, 2'b10, 0, 16'h0, 16'h0400, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 2'b11, 1, 16'h0, 16'h0700, 1, 0);
      checks++;
      if (obs !== {16'h0400, 4'b0000}) begin
        errors++; $display("FAIL hold_%0d: got %h want %h", i, obs, {16'h0400, 4'b0000});
      end
    end
    step(1, 2'b10, 0, 16'h0, 16'h0205, 0, 0);
    checks++;
    if ({pc_out, align_fault} !== {16'h0204, 1'b1}) begin
      errors++; $display("FAIL align: got %h/%b want 0204/1", pc_out, align_fault);
    end
    step(1, 2'b11, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (obs !== exp_vec() || align_fault !== 1'b0) begin
      errors++; $display("FAIL align_pulse_ret: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    step(1, 2'b11, 0, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 2'b10, 0, 16'h0, 16'h0A00 + 16'(i * 16), 1, 0);
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL pre_reset: got %h want %h", obs, exp_vec());
    end
    do_reset(1);
    checks++;
    if (obs !== 20'h0_0008) begin
      errors++; $display("FAIL mid_reset: got %h want %h", obs, 20'h0_0008);
    end
  endtask

  task automatic test_random();
    logic [1:0] src;
    for (int i = 0; i < 400; i++) begin
      src = 2'($urandom_range(0, 3));
      step(1'($urandom_range(0, 3) != 0), src, 1'($urandom), 16'($urandom),
           16'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL rand_%0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_ret();
    test_overflow();
    test_hold_align();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
